ibex_lsu_resp_tracker: RTL and testbench

- Sits between the data-bus response channel and the writeback stage, on the producing side of the LSU-to-writeback interface.
- Records attributes of every accepted load/store bus request and matches in-order bus responses against them.
- Merges the two beats of misaligned (split) accesses, then aligns and sign/zero-extends load data.
- Drives rf_wdata_lsu / rf_we_lsu / lsu_resp_valid / lsu_resp_err toward writeback in the same cycle the final beat arrives.

---
 rtl/ibex_lsu_resp_tracker.sv | 161 ++++++++++++++++
 tb/tb_ibex_lsu_resp_tracker.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_lsu_resp_tracker.sv
// LSU response tracker: records accepted bus requests, matches in-order responses,
// merges split beats and formats load data toward writeback in the response cycle.
module ibex_lsu_resp_tracker #(
    parameter int unsigned MaxOutstanding = 2,
    parameter bit          ResetAll       = 1'b0,
    localparam int unsigned CntW          = $clog2(MaxOutstanding + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic            req_we_i,
    input  logic [1:0]      req_type_i,
    input  logic            req_sign_ext_i,
    input  logic [1:0]      req_offset_i,
    input  logic            req_split_i,
    input  logic            data_rvalid_i,
    input  logic [31:0]     data_rdata_i,
    input  logic            data_err_i,
    output logic [31:0]     rf_wdata_lsu_o,
    output logic            rf_we_lsu_o,
    output logic            lsu_resp_valid_o,
    output logic            lsu_resp_err_o,
    output logic [CntW-1:0] outstanding_o,
    output logic            spurious_resp_o
);

    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

    typedef struct packed {
        logic       we;
        logic [1:0] typ;
        logic       sign;
        logic [1:0] offset;
        logic       split;
    } entry_t;

    typedef enum logic {
        WAIT_FIRST  = 1'b0,
        WAIT_SECOND = 1'b1
    } state_e;

    entry_t          entries_q [MaxOutstanding];
    entry_t          req_entry;
    entry_t          head;
    logic [PtrW-1:0] wptr_q, rptr_q;
    logic [CntW-1:0] count_q;
    state_e          state_q, state_d;
    logic            err_q, err_d;
    logic [31:0]     rdata_q;
    logic            empty, push, pop, capture, final_beat;
    logic [63:0]     wide;
    logic [31:0]     shifted;
    logic [31:0]     fmt;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign req_entry = '{we: req_we_i, typ: req_type_i, sign: req_sign_ext_i,
                         offset: req_offset_i, split: req_split_i};
    assign head        = entries_q[rptr_q];
    assign empty       = (count_q == '0);
    assign req_ready_o = (count_q != CntW'(MaxOutstanding));
    assign push        = req_valid_i & req_ready_o;
    assign pop         = final_beat;
    assign outstanding_o = count_q;

    // Head FSM: a split entry captures its first beat, the second beat completes it
    always_comb begin
        state_d    = state_q;
        err_d      = err_q;
        capture    = 1'b0;
        final_beat = 1'b0;
        if (data_rvalid_i && !empty) begin
            case (state_q)
                WAIT_FIRST: begin
                    if (head.split) begin
                        capture = 1'b1;
                        err_d   = data_err_i;
                        state_d = WAIT_SECOND;
                    end else begin
                        final_beat = 1'b1;
                    end
                end
                WAIT_SECOND: begin
                    final_beat = 1'b1;
                    err_d      = 1'b0;
                    state_d    = WAIT_FIRST;
                end
                default: state_d = WAIT_FIRST;
            endcase
        end
    end

    // Zero-latency response formatting from the final beat
    always_comb begin
        wide    = head.split ? {data_rdata_i, rdata_q} : {32'b0, data_rdata_i};
        shifted = 32'(wide >> {head.offset, 3'b000});
        case (head.typ)
            2'b01:   fmt = {{16{head.sign & shifted[15]}}, shifted[15:0]};
            2'b10:   fmt = {{24{head.sign & shifted[7]}}, shifted[7:0]};
            default: fmt = shifted;
        endcase
        lsu_resp_valid_o = final_beat;
        lsu_resp_err_o   = final_beat & (data_err_i | err_q);
        rf_we_lsu_o      = final_beat & ~head.we & ~lsu_resp_err_o;
        rf_wdata_lsu_o   = rf_we_lsu_o ? fmt : '0;
        spurious_resp_o  = data_rvalid_i & empty & rst_ni;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            state_q <= WAIT_FIRST;
            err_q   <= 1'b0;
        end else begin
            if (push) wptr_q <= ptr_inc(wptr_q);
            if (pop)  rptr_q <= ptr_inc(rptr_q);
            count_q <= count_q + CntW'(push) - CntW'(pop);
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    // Payload storage; reset only when ResetAll is requested
    if (ResetAll) begin : g_dp_reset
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int i = 0; i < int'(MaxOutstanding); i++) entries_q[i] <= '0;
                rdata_q <= '0;
            end else begin
                if (push)    entries_q[wptr_q] <= req_entry;
                if (capture) rdata_q <= data_rdata_i;
            end
        end
    end else begin : g_dp_noreset
        always_ff @(posedge clk_i) begin
            if (push)    entries_q[wptr_q] <= req_entry;
            if (capture) rdata_q <= data_rdata_i;
        end
    end

    a_push_not_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
        req_valid_i |-> req_ready_o);
    a_type_legal: assert property (@(posedge clk_i) disable iff (!rst_ni)
        req_valid_i |-> (req_type_i != 2'b11));
    a_no_cross: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (req_valid_i && !req_split_i) |->
        !((req_type_i == 2'b00 && req_offset_i != 2'b00) ||
          (req_type_i == 2'b01 && req_offset_i == 2'b11)));
    a_valid_nonempty: assert property (@(posedge clk_i) disable iff (!rst_ni)
        lsu_resp_valid_o |-> !empty);
    a_we_valid: assert property (@(posedge clk_i) disable iff (!rst_ni)
        rf_we_lsu_o |-> lsu_resp_valid_o);
    a_count_max: assert property (@(posedge clk_i) disable iff (!rst_ni)
        count_q <= CntW'(MaxOutstanding));

endmodule

// File: tb/tb_ibex_lsu_resp_tracker.sv
// Scoreboard bench for ibex_lsu_resp_tracker: stimulus queues expected responses,
// a negedge monitor pops and compares them whenever the DUT signals a response.
module tb_ibex_lsu_resp_tracker;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_valid_i, req_ready_o, req_we_i, req_sign_ext_i, req_split_i;
    logic [1:0]  req_type_i, req_offset_i;
    logic        data_rvalid_i, data_err_i;
    logic [31:0] data_rdata_i, rf_wdata_lsu_o;
    logic        rf_we_lsu_o, lsu_resp_valid_o, lsu_resp_err_o, spurious_resp_o;
    logic [1:0]  outstanding_o;

    typedef struct {
        logic        we;
        logic [31:0] wdata;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   spur_seen = 0;

    ibex_lsu_resp_tracker #(.MaxOutstanding(2), .ResetAll(1'b0)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .req_we_i        (req_we_i),
        .req_type_i      (req_type_i),
        .req_sign_ext_i  (req_sign_ext_i),
        .req_offset_i    (req_offset_i),
        .req_split_i     (req_split_i),
        .data_rvalid_i   (data_rvalid_i),
        .data_rdata_i    (data_rdata_i),
        .data_err_i      (data_err_i),
        .rf_wdata_lsu_o  (rf_wdata_lsu_o),
        .rf_we_lsu_o     (rf_we_lsu_o),
        .lsu_resp_valid_o(lsu_resp_valid_o),
        .lsu_resp_err_o  (lsu_resp_err_o),
        .outstanding_o   (outstanding_o),
        .spurious_resp_o (spurious_resp_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input logic we, input logic [1:0] typ, input logic sign,
                        input logic [1:0] off, input logic split);
        req_valid_i = 1'b1; req_we_i = we; req_type_i = typ;
        req_sign_ext_i = sign; req_offset_i = off; req_split_i = split;
        tick();
        req_valid_i = 1'b0;
    endtask

    task automatic beat(input logic [31:0] d, input logic err);
        data_rvalid_i = 1'b1; data_rdata_i = d; data_err_i = err;
        tick();
        data_rvalid_i = 1'b0; data_err_i = 1'b0;
    endtask

    task automatic sb_push(input logic we, input logic [31:0] wdata, input logic err);
        exp_t e;
        e.we = we; e.wdata = wdata; e.err = err;
        exp_q.push_back(e);
    endtask

    // Monitor: every response must match the oldest queued expectation
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (spurious_resp_o) spur_seen++;
            if (lsu_resp_valid_o) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_resp: got resp_valid=1 required no response");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("resp_we", 32'(rf_we_lsu_o), 32'(e.we));
                    check("resp_err", 32'(lsu_resp_err_o), 32'(e.err));
                    check("resp_wdata", rf_wdata_lsu_o, e.wdata);
                end
            end else if (rf_we_lsu_o) begin
                tests++;
                fails++;
                $display("FAIL we_without_valid: got rf_we=1 required 0");
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [31:0] t_data [5] = '{32'h01234567, 32'h55555555, 32'hABCD1234, 32'h66666666, 32'h0000F000};
    logic [31:0] t_exp  [5] = '{32'h01234567, 32'h00000000, 32'h0000ABCD, 32'h00000000, 32'hFFFFFFF0};
    logic        t_we   [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [1:0]  t_typ  [5] = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b10};
    logic        t_sign [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [1:0]  t_off  [5] = '{2'd0, 2'd0, 2'd2, 2'd0, 2'd1};

    initial begin
        int s0;
        rst_ni = 1'b0;
        req_valid_i = 1'b0; req_we_i = 1'b0; req_type_i = 2'b00; req_sign_ext_i = 1'b0;
        req_offset_i = 2'b00; req_split_i = 1'b0;
        data_rvalid_i = 1'b1; data_rdata_i = 32'hFFFFFFFF; data_err_i = 1'b0;

        // Outputs held quiet during reset even with a response on the bus
        @(negedge clk_i);
        @(negedge clk_i);
        check("rst_ready", 32'(req_ready_o), 32'd1);
        check("rst_outstanding", 32'(outstanding_o), 32'd0);
        check("rst_valid", 32'(lsu_resp_valid_o), 32'd0);
        check("rst_we", 32'(rf_we_lsu_o), 32'd0);
        check("rst_wdata", rf_wdata_lsu_o, 32'd0);
        check("rst_spurious", 32'(spurious_resp_o), 32'd0);
        @(posedge clk_i);
        #1;
        data_rvalid_i = 1'b0;
        rst_ni = 1'b1;
        tick();

        // Aligned word load
        push(1'b0, 2'b00, 1'b0, 2'd0, 1'b0);
        check("word_outst_1", 32'(outstanding_o), 32'd1);
        sb_push(1'b1, 32'hDEADBEEF, 1'b0);
        beat(32'hDEADBEEF, 1'b0);
        check("word_outst_0", 32'(outstanding_o), 32'd0);

        // Byte / half extraction at offset 2
        push(1'b0, 2'b10, 1'b1, 2'd2, 1'b0);
        sb_push(1'b1, 32'hFFFFFF80, 1'b0);
        beat(32'h12803456, 1'b0);
        push(1'b0, 2'b10, 1'b0, 2'd2, 1'b0);
        sb_push(1'b1, 32'h00000080, 1'b0);
        beat(32'h12803456, 1'b0);
        push(1'b0, 2'b01, 1'b1, 2'd2, 1'b0);
        sb_push(1'b1, 32'h00001280, 1'b0);
        beat(32'h12803456, 1'b0);

        // Split word at offset 1
        push(1'b0, 2'b00, 1'b0, 2'd1, 1'b1);
        beat(32'h44332211, 1'b0);
        check("split_hold", 32'(outstanding_o), 32'd1);
        sb_push(1'b1, 32'h55443322, 1'b0);
        beat(32'h88776655, 1'b0);
        check("split_done", 32'(outstanding_o), 32'd0);

        // Split half with first-beat error, then a normal load
        push(1'b0, 2'b01, 1'b1, 2'd3, 1'b1);
        beat(32'hAABBCCDD, 1'b1);
        sb_push(1'b0, 32'h00000000, 1'b1);
        beat(32'h11223344, 1'b0);
        push(1'b0, 2'b00, 1'b0, 2'd0, 1'b0);
        sb_push(1'b1, 32'hCAFEF00D, 1'b0);
        beat(32'hCAFEF00D, 1'b0);

        // Fill, hold off, then simultaneous push and pop at count 1
        push(1'b0, 2'b00, 1'b0, 2'd0, 1'b0);
        push(1'b1, 2'b00, 1'b0, 2'd0, 1'b0);
        check("full_ready", 32'(req_ready_o), 32'd0);
        check("full_outst", 32'(outstanding_o), 32'd2);
        tick();
        check("full_hold", 32'(req_ready_o), 32'd0);
        sb_push(1'b1, 32'h11111111, 1'b0);
        beat(32'h11111111, 1'b0);
        check("drain_outst", 32'(outstanding_o), 32'd1);
        check("drain_ready", 32'(req_ready_o), 32'd1);
        sb_push(1'b0, 32'h00000000, 1'b0);
        req_valid_i = 1'b1; req_we_i = 1'b0; req_type_i = 2'b00;
        req_sign_ext_i = 1'b0; req_offset_i = 2'd0; req_split_i = 1'b0;
        data_rvalid_i = 1'b1; data_rdata_i = 32'h99999999; data_err_i = 1'b0;
        tick();
        req_valid_i = 1'b0; data_rvalid_i = 1'b0;
        check("pushpop_outst", 32'(outstanding_o), 32'd1);
        sb_push(1'b1, 32'h22222222, 1'b0);
        beat(32'h22222222, 1'b0);
        check("pushpop_drain", 32'(outstanding_o), 32'd0);

        // Load/store mix over wrapping pointers, two in flight
        for (int i = 0; i < 5; i += 2) begin
            push(t_we[i], t_typ[i], t_sign[i], t_off[i], 1'b0);
            if (i < 4) push(t_we[i+1], t_typ[i+1], t_sign[i+1], t_off[i+1], 1'b0);
            sb_push(~t_we[i], t_exp[i], 1'b0);
            beat(t_data[i], 1'b0);
            if (i < 4) begin
                sb_push(~t_we[i+1], t_exp[i+1], 1'b0);
                beat(t_data[i+1], 1'b0);
            end
        end
        check("mix_outst", 32'(outstanding_o), 32'd0);

        // Response with empty FIFO
        s0 = spur_seen;
        beat(32'h12345678, 1'b0);
        check("spurious_empty", 32'(spur_seen), 32'(s0 + 1));
        check("spurious_outst", 32'(outstanding_o), 32'd0);

        // Reset while waiting for a second beat
        push(1'b0, 2'b00, 1'b0, 2'd1, 1'b1);
        beat(32'h44332211, 1'b0);
        rst_ni = 1'b0;
        tick();
        check("midrst_outst", 32'(outstanding_o), 32'd0);
        rst_ni = 1'b1;
        tick();
        s0 = spur_seen;
        beat(32'h88776655, 1'b0);
        check("midrst_spurious", 32'(spur_seen), 32'(s0 + 1));
        push(1'b0, 2'b00, 1'b0, 2'd0, 1'b0);
        sb_push(1'b1, 32'h0BADF00D, 1'b0);
        beat(32'h0BADF00D, 1'b0);

        tick();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
